// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arbiter_if
//  Description : Bus bundle between the VRAM arbiter, the graphics engine,
//                the CPU bus, the VRAM macro and the statistics registers.
//                slave  = arbiter view, master = surrounding system view.
//  Revision    : 1.0  initial release
// ============================================================================
interface vram_arbiter_if #(
    parameter int ADDR_W = 11
);
    // Graphics engine port
    logic              gfx_req_i;
    logic [ADDR_W-1:0] gfx_addr_i;
    logic [31:0]       gfx_rdata_o;

    // CPU port
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [31:0]       cpu_wdata_i;
    logic [3:0]        cpu_wstrb_i;
    logic              cpu_ack_o;
    logic [31:0]       cpu_rdata_o;

    // VRAM macro port
    logic [ADDR_W-1:0] mem_addr_o;
    logic [3:0]        mem_we_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    // Wait statistics
    logic              stat_clr_i;
    logic [7:0]        stall_max_o;
    logic              starve_o;

    modport slave (
        input  gfx_req_i, gfx_addr_i,
        output gfx_rdata_o,
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_wstrb_i,
        output cpu_ack_o, cpu_rdata_o,
        output mem_addr_o, mem_we_o, mem_wdata_o,
        input  mem_rdata_i,
        input  stat_clr_i,
        output stall_max_o, starve_o
    );

    modport master (
        output gfx_req_i, gfx_addr_i,
        input  gfx_rdata_o,
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_wstrb_i,
        input  cpu_ack_o, cpu_rdata_o,
        input  mem_addr_o, mem_we_o, mem_wdata_o,
        output mem_rdata_i,
        output stat_clr_i,
        input  stall_max_o, starve_o
    );
endinterface
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vram_arbiter
//  Description : Shares a single-port 1-cycle-latency VRAM between the
//                graphics engine (absolute priority, never delayed) and the
//                CPU bus (held request, issued in free cycles). Records the
//                worst CPU blocked time and a sticky starvation flag.
//  Revision    : 1.0  initial release
// ============================================================================
module vram_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int STARVE_LIMIT = 64
) (
    input logic           clk,
    input logic           rst,
    vram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);
    localparam logic [7:0] c_wait_max     = 8'hFF;

    state_t            r_state;
    state_t            w_state_next;

    // Held CPU request
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;

    logic [7:0]        r_wait_cnt;
    logic [7:0]        w_wait_inc;
    logic [31:0]       r_rdata;
    logic [7:0]        r_stall_max;
    logic              r_starve;

    logic [ADDR_W-1:0] w_mem_addr;
    logic [3:0]        w_mem_we;
    logic              w_cpu_ack;
    logic [31:0]       w_cpu_rdata;

    assign w_wait_inc = (r_wait_cnt == c_wait_max) ? c_wait_max : r_wait_cnt + 8'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, memory mux and CPU completion outputs
    always_comb begin
        w_state_next = r_state;
        w_mem_addr   = bus.gfx_addr_i;
        w_mem_we     = 4'h0;
        w_cpu_ack    = 1'b0;
        w_cpu_rdata  = r_rdata;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_req_i) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Graphics owns the cycle whenever it asks; CPU waits.
                if (!bus.gfx_req_i) begin
                    w_mem_addr   = r_addr;
                    w_mem_we     = r_we ? r_wstrb : 4'h0;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // Data on mem_rdata_i now belongs to the CPU address issued
                // last cycle, regardless of what graphics drives this cycle.
                w_cpu_ack = 1'b1;
                if (!r_we) begin
                    w_cpu_rdata = bus.mem_rdata_i;
                end
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Capture CPU request, count blocked cycles, hold returned read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= 32'h0;
            r_wstrb    <= 4'h0;
            r_wait_cnt <= 8'h0;
            r_rdata    <= 32'h0;
        end else begin
            if (r_state == S_IDLE && bus.cpu_req_i) begin
                r_addr     <= bus.cpu_addr_i;
                r_we       <= bus.cpu_we_i;
                r_wdata    <= bus.cpu_wdata_i;
                r_wstrb    <= bus.cpu_wstrb_i;
                r_wait_cnt <= 8'h0;
            end
            if (r_state == S_ISSUE && bus.gfx_req_i) begin
                r_wait_cnt <= w_wait_inc;
            end
            if (r_state == S_DONE && !r_we) begin
                r_rdata <= bus.mem_rdata_i;
            end
        end
    end

    // Wait statistics; a clear request overrides any simultaneous update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_max <= 8'h0;
            r_starve    <= 1'b0;
        end else if (bus.stat_clr_i) begin
            r_stall_max <= 8'h0;
            r_starve    <= 1'b0;
        end else begin
            if (r_state == S_DONE && r_wait_cnt > r_stall_max) begin
                r_stall_max <= r_wait_cnt;
            end
            if (r_state == S_ISSUE && bus.gfx_req_i && w_wait_inc >= c_starve_limit) begin
                r_starve <= 1'b1;
            end
        end
    end

    assign bus.gfx_rdata_o = bus.mem_rdata_i;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_wdata_o = r_wdata;
    assign bus.cpu_ack_o   = w_cpu_ack;
    assign bus.cpu_rdata_o = w_cpu_rdata;
    assign bus.stall_max_o = r_stall_max;
    assign bus.starve_o    = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vram_arbiter
//  Description : Scoreboard bench for vram_arbiter. The driver pushes the
//                expected outcome of each CPU request (ack cycle, read data,
//                resulting statistics) into a queue; a monitor pops and
//                compares on every ack. A bench-owned VRAM model sits on
//                the memory port.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vram_arbiter;

    localparam int ADDR_W       = 11;
    localparam int STARVE_LIMIT = 64;

    typedef struct {
        bit          we;
        logic [31:0] rdata;
        int          ack_cyc;
        logic [7:0]  smax;
        bit          starve;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    vram_arbiter #(
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Environment VRAM and reference-model shadow of CPU-visible contents
    bit [31:0] vram   [0:2047];
    bit [31:0] shadow [0:2047];
    exp_t      q [$];
    int        m_smax   = 0;
    bit        m_starve = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Single-port VRAM, 1-cycle read latency, byte-enabled writes
    always @(posedge clk) begin
        if (|bus.mem_we_o) vram[bus.mem_addr_o] <= merge(vram[bus.mem_addr_o], bus.mem_wdata_o, bus.mem_we_o);
        bus.mem_rdata_i <= vram[bus.mem_addr_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit          prev_gfx_req = 0;
    logic [10:0] prev_gfx_addr = '0;
    bit          stat_pending = 0;
    exp_t        stat_e;
    exp_t        mon_e;
    logic [31:0] last_rd = 32'h0;

    always @(negedge clk) begin
        if (rst) begin
            stat_pending = 0;
            last_rd      = 32'h0;
            prev_gfx_req = 0;
        end else begin
            if (prev_gfx_req) check("gfx_rdata", bus.gfx_rdata_o, vram[prev_gfx_addr]);
            if (bus.gfx_req_i) begin
                check("gfx_mem_addr", 32'(bus.mem_addr_o), 32'(bus.gfx_addr_i));
                check("gfx_mem_we", 32'(bus.mem_we_o), 32'h0);
            end
            prev_gfx_req  = bus.gfx_req_i;
            prev_gfx_addr = bus.gfx_addr_i;

            if (stat_pending) begin
                check("stall_max", 32'(bus.stall_max_o), 32'(stat_e.smax));
                check("starve", 32'(bus.starve_o), 32'(stat_e.starve));
                check("rdata_hold", bus.cpu_rdata_o, last_rd);
                stat_pending = 0;
            end

            if (bus.cpu_ack_o) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_ack: got ack=1 expected no ack (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    check("ack_cycle", 32'(cyc), 32'(mon_e.ack_cyc));
                    if (!mon_e.we) begin
                        check("cpu_rdata", bus.cpu_rdata_o, mon_e.rdata);
                        last_rd = mon_e.rdata;
                    end
                    stat_e       = mon_e;
                    stat_pending = 1;
                end
            end

            if (q.size() > 0 && cyc > q[0].ack_cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL ack_timeout: got no ack expected ack at cycle %0d (cycle %0d)", q[0].ack_cyc, cyc);
                q.delete(0);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    // Graphics holds the bus for exactly 'blocked' cycles after capture.
    task automatic do_txn(input bit we, input logic [10:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int blocked, input bit gfx_in_done);
        exp_t e;
        @(posedge clk); #1;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wdata;
        bus.cpu_wstrb_i = wstrb;
        bus.stat_clr_i  = 1'b0;
        bus.gfx_req_i   = 1'($urandom_range(0, 1));
        bus.gfx_addr_i  = 11'($urandom_range(0, 2047));
        e.we      = we;
        e.ack_cyc = cyc + blocked + 2;
        if (we) begin
            shadow[addr] = merge(shadow[addr], wdata, wstrb);
            e.rdata      = 32'h0;
        end else begin
            e.rdata = shadow[addr];
        end
        m_smax = (blocked > 255) ? 255 : ((blocked > m_smax) ? blocked : m_smax);
        if (blocked >= STARVE_LIMIT) m_starve = 1;
        e.smax   = 8'(m_smax);
        e.starve = m_starve;
        q.push_back(e);
        repeat (blocked) begin
            @(posedge clk); #1;
            bus.gfx_req_i  = 1'b1;
            bus.gfx_addr_i = 11'($urandom_range(0, 2047));
        end
        @(posedge clk); #1;
        bus.gfx_req_i = 1'b0;
        @(posedge clk); #1;
        bus.gfx_req_i  = gfx_in_done ? 1'b1 : 1'($urandom_range(0, 1));
        bus.gfx_addr_i = 11'($urandom_range(0, 2047));
    endtask

    task automatic idle(input int n, input bit clr_first);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.cpu_req_i  = 1'b0;
            bus.stat_clr_i = (i == 0) ? clr_first : 1'b0;
            bus.gfx_req_i  = 1'($urandom_range(0, 1));
            bus.gfx_addr_i = 11'($urandom_range(0, 2047));
            if (i == 0 && clr_first) begin
                m_smax   = 0;
                m_starve = 0;
            end
        end
    endtask

    task automatic clear_and_check();
        idle(1, 1'b1);
        @(posedge clk); #1;
        bus.stat_clr_i = 1'b0;
        check("clr_stall_max", 32'(bus.stall_max_o), 32'h0);
        check("clr_starve", 32'(bus.starve_o), 32'h0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.gfx_req_i   = 1'b0;
        bus.gfx_addr_i  = '0;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.cpu_wdata_i = 32'h0;
        bus.cpu_wstrb_i = 4'h0;
        bus.stat_clr_i  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus.cpu_ack_o), 32'h0);
        check("rst_rdata", bus.cpu_rdata_o, 32'h0);
        check("rst_stall_max", 32'(bus.stall_max_o), 32'h0);
        check("rst_starve", 32'(bus.starve_o), 32'h0);
        check("rst_mem_we", 32'(bus.mem_we_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle graphics: write then back-to-back read
        do_txn(1'b1, 11'h400, 32'hDEADBEEF, 4'hF, 0, 1'b0);
        do_txn(1'b0, 11'h400, 32'h0, 4'h0, 0, 1'b0);
        idle(1, 1'b0);
        // Graphics holds the bus for 10 cycles
        do_txn(1'b1, 11'h010, 32'h0BADF00D, 4'hF, 0, 1'b0);
        do_txn(1'b0, 11'h010, 32'h0, 4'h0, 10, 1'b0);
        // Graphics request in the ack cycle of a CPU read
        do_txn(1'b0, 11'h400, 32'h0, 4'h0, 0, 1'b1);
        // Byte strobes, then a zero-strobe write that must not change memory
        do_txn(1'b1, 11'h020, 32'h11223344, 4'hF, 1, 1'b0);
        do_txn(1'b1, 11'h020, 32'hAABBCCDD, 4'h2, 0, 1'b0);
        do_txn(1'b0, 11'h020, 32'h0, 4'h0, 2, 1'b0);
        do_txn(1'b1, 11'h020, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
        do_txn(1'b0, 11'h020, 32'h0, 4'h0, 0, 1'b0);
        idle(1, 1'b0);
        clear_and_check();

        // Starvation: 70 blocked cycles, flag stays set past the ack
        do_txn(1'b0, 11'h010, 32'h0, 4'h0, 70, 1'b0);
        idle(2, 1'b0);
        clear_and_check();

        // Reset while a write is waiting in the issue state
        do_txn(1'b0, 11'h400, 32'h0, 4'h0, 7, 1'b0);
        @(posedge clk); #1;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = 1'b1;
        bus.cpu_addr_i  = 11'h400;
        bus.cpu_wdata_i = 32'h12345678;
        bus.cpu_wstrb_i = 4'hF;
        bus.gfx_req_i   = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            bus.gfx_req_i = 1'b1;
        end
        #2;
        rst           = 1'b1;
        bus.gfx_req_i = 1'b0;
        #1;
        check("arst_ack", 32'(bus.cpu_ack_o), 32'h0);
        check("arst_rdata", bus.cpu_rdata_o, 32'h0);
        check("arst_stall_max", 32'(bus.stall_max_o), 32'h0);
        check("arst_starve", 32'(bus.starve_o), 32'h0);
        check("arst_mem_we", 32'(bus.mem_we_o), 32'h0);
        @(posedge clk); #1;
        bus.cpu_req_i = 1'b0;
        rst           = 1'b0;
        m_smax        = 0;
        m_starve      = 0;
        idle(4, 1'b0);
        do_txn(1'b0, 11'h400, 32'h0, 4'h0, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            int          blk;
            bit          we;
            logic [3:0]  strb;
            int          gap;
            blk  = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 3) : $urandom_range(4, 15);
            we   = 1'($urandom_range(0, 1));
            strb = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            do_txn(we, 11'($urandom_range(0, 31)), $urandom, strb, blk, 1'b0);
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(gap, ($urandom_range(0, 5) == 0));
        end

        idle(6, 1'b0);
        check("queue_drain", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000 ns");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port synchronous VRAM (2048 x 32) between the graphics engine and the CPU bus.
- The graphics engine has absolute priority and must never be delayed: sprite/tile fetch timing is fixed to the video beam.
- CPU reads and writes are captured into a holding register and issued in cycles the graphics engine leaves free.
- Tracks CPU wait statistics so firmware can detect starvation during active display.

Parameters:
ADDR_W, 11, VRAM word address width (2048 words)
STARVE_LIMIT, 64, blocked-cycle count at which starve_o asserts (1..255)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
gfx_req_i  in  1  graphics engine needs VRAM this cycle
gfx_addr_i  in  ADDR_W  graphics read address
gfx_rdata_o  out  32  graphics read data, valid the cycle after gfx_req_i
cpu_req_i  in  1  CPU request; held with stable addr/data/we/wstrb until cpu_ack_o
cpu_we_i  in  1  1 = write, 0 = read
cpu_addr_i  in  ADDR_W  CPU word address
cpu_wdata_i  in  32  CPU write data
cpu_wstrb_i  in  4  byte enables for writes
cpu_ack_o  out  1  one-cycle completion pulse
cpu_rdata_o  out  32  read data, valid while cpu_ack_o=1 for reads
mem_addr_o  out  ADDR_W  VRAM address
mem_we_o  out  4  VRAM byte write enables
mem_wdata_o  out  32  VRAM write data
mem_rdata_i  in  32  VRAM read data, 1-cycle latency
stat_clr_i  in  1  clears stall_max_o and starve_o
stall_max_o  out  8  maximum blocked cycles seen on any CPU request, saturating at 255
starve_o  out  1  sticky; set when a request's blocked count reaches STARVE_LIMIT

Behaviour:
- Reset: state S_IDLE; cpu_ack_o=0, cpu_rdata_o=0, stall_max_o=0, starve_o=0, holding registers 0, wait counter 0. mem_* follow the mux, so mem_we_o=0 throughout reset.
- Reset mid-request: the pending request is dropped with no ack. The CPU side must re-issue it.
- Mux (combinational):
  - gfx_req_i=1: mem_addr_o=gfx_addr_i, mem_we_o=0.
  - else state S_ISSUE: drive the held CPU address/data; mem_we_o=held wstrb if write, else 0.
  - else: mem_addr_o=gfx_addr_i, mem_we_o=0.
- gfx_rdata_o = mem_rdata_i, combinational pass-through.
- FSM:
  - S_IDLE: if cpu_req_i, latch addr/we/wdata/wstrb, clear the wait counter, go to S_ISSUE.
  - S_ISSUE: if gfx_req_i, stay and increment the wait counter (saturating at 255). Else the memory access happens this cycle; go to S_DONE.
  - S_DONE: cpu_ack_o=1. For reads, cpu_rdata_o <= mem_rdata_i at entry, so it is valid during ack. This holds even if gfx_req_i=1 in that cycle, because the returned data belongs to the previous-cycle CPU address. Update stall_max_o <= max(stall_max_o, wait counter). Go to S_IDLE.
- cpu_rdata_o holds its value until the next read ack.
- Handshake:
  - The requester may deassert cpu_req_i or present a new request in the cycle after ack.
  - The S_IDLE cycle guarantees no double-capture of a request.
  - Minimum latency is 2 cycles from first req cycle to ack; each blocked cycle adds 1.
  - Back-to-back throughput is one access per 3 cycles.
- Write with wstrb=0: issued and acked normally; memory is unchanged.
- starve_o: set in the cycle the wait counter reaches STARVE_LIMIT while in S_ISSUE. Stays set until stat_clr_i.
- stat_clr_i coinciding with a set/update event: clear wins.
- Address arithmetic: none; addresses pass through unmodified at ADDR_W bits.

Test Plan:
- Idle gfx: CPU write addr 0x400, data 0xDEADBEEF, wstrb 0xF -> mem_we_o=0xF for 1 cycle at 0x400; ack 2 cycles after req. A following read of 0x400 returns 0xDEADBEEF with ack; stall_max_o=0.
- gfx_req_i held high 10 cycles during a pending CPU read of 0x010 -> no CPU memory cycle during those 10 cycles; gfx addresses reach mem_addr_o unchanged; ack comes 12 cycles after req; stall_max_o=10.
- CPU read issued, then gfx_req_i=1 in the S_DONE cycle -> cpu_rdata_o holds the CPU word; gfx_rdata_o is valid the following cycle for the gfx address.
- gfx_req_i high for 70 cycles with a pending request, STARVE_LIMIT=64 -> starve_o rises after 64 blocked cycles and stays high after ack. Pulse stat_clr_i -> starve_o=0, stall_max_o=0.
- Byte strobe write: wstrb=0x2 to a word holding 0x11223344 with wdata 0xAABBCCDD -> memory word becomes 0x1122CC44.
- Assert rst while in S_ISSUE -> all outputs return to 0 asynchronously, no ack is generated, and a fresh request after reset completes normally.
